// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the signed-product to sign + packed BCD converter.
// Optional blanking of leading zero digits is enabled by PRODUCT_BCD_BLANK_EN.
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          DIGIT_W        = 4;
  localparam int          ADD3_THRESHOLD = 5;
  localparam logic [3:0]  BLANK_CODE     = 4'hF;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
  import product_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= DIGIT_W'(ADD3_THRESHOLD)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/product_bcd_converter.sv
// Captures a two's-complement product and converts it to sign + packed BCD by double-dabble.
// Define PRODUCT_BCD_BLANK_EN to show leading zero digits (except digit 0) as the blank code.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          res_in,
  output logic                      busy,
  output logic                      done,
  output logic                      sinal_out,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output state_t                    state_dbg
);

  // Handshake: start is taken only while busy is low; busy stays high from the
  // capture edge until the cycle after the one-cycle done pulse. Results on
  // bcd/sinal_out are valid from done and held until the next completion.

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;

  state_t             state;
  logic [WIDTH-1:0]   cap_q;
  logic [WIDTH-1:0]   bin_q;
  logic               sign_q;
  logic [BCD_W-1:0]   acc_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sinal_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   magnitude;
  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic               last_iter;

  // The most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  assign magnitude = sign_q ? (~cap_q + WIDTH'(1)) : cap_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_in  (acc_q[g*DIGIT_W +: DIGIT_W]),
      .digit_out (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign acc_shift = {acc_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cap_q   <= '0;
      bin_q   <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sinal_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cap_q  <= res_in;
            sign_q <= res_in[WIDTH-1];
            busy_q <= 1'b1;
            state  <= ABS;
          end
        end
        ABS: begin
          bin_q <= magnitude;
          acc_q <= '0;
          cnt_q <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          acc_q <= acc_shift;
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            bcd_q   <= acc_shift;
            sinal_q <= sign_q;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sinal_out = sinal_q;
  assign state_dbg = state;

`ifdef PRODUCT_BCD_BLANK_EN
  logic [BCD_W-1:0] bcd_disp;
  logic             seen_nonzero;

  // Scan from the top digit down; digit 0 is never blanked.
  always_comb begin
    bcd_disp     = bcd_q;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!seen_nonzero && (bcd_q[i*DIGIT_W +: DIGIT_W] == '0)) begin
        bcd_disp[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
      end else begin
        seen_nonzero = 1'b1;
      end
    end
  end

  assign bcd = bcd_disp;
`else
  assign bcd = bcd_q;
`endif

endmodule
